// File: rtl/lab_pkg.sv
// Shared types and constants for the preset sequencer: slot count, FSM
// state encoding and the factory-default value of every parameter.
package lab_pkg;

  localparam int PRESET_COUNT = 4;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    LOAD,
    LOAD_TAIL,
    DONE
  } seq_state_t;

  // Factory value returned when an empty slot is loaded; callers truncate
  // to their parameter width.
  function automatic int unsigned param_default(input int unsigned fx,
                                                input int unsigned param);
    return (fx * 8 + param * 5 + 32) & 32'h7f;
  endfunction

endpackage

// File: rtl/preset_ram.sv
// Single-port synchronous preset storage with a one-cycle registered read.
// Contents are deliberately not cleared by reset.
module preset_ram #(
  parameter int DEPTH = 512,
  parameter int W     = 7,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/preset_sequencer.sv
// Saves the live parameter bank into a preset slot, or replays a slot back
// into the controller as a stream of single-word writes.
import lab_pkg::*;

module preset_sequencer #(
  parameter int FX_COUNT     = 16,
  parameter int PARAM_COUNT  = 8,
  parameter int PARAM_W      = 7,
  parameter int PRESET_COUNT = lab_pkg::PRESET_COUNT
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               save_req,
  input  logic                                               load_req,
  input  logic [$clog2(PRESET_COUNT)-1:0]                    preset_sel,
  input  logic [FX_COUNT-1:0][PARAM_COUNT-1:0][PARAM_W-1:0]  params,
  output logic                                               busy,
  output logic                                               lock,
  output logic                                               done,
  output logic                                               wr_en,
  output logic [$clog2(FX_COUNT)-1:0]                        wr_fx,
  output logic [$clog2(PARAM_COUNT)-1:0]                     wr_param,
  output logic [PARAM_W-1:0]                                 wr_data,
  output logic [PRESET_COUNT-1:0]                            slot_valid,
  output seq_state_t                                         dbg_state
);

  localparam int SEL_W = $clog2(PRESET_COUNT);
  localparam int FX_W  = $clog2(FX_COUNT);
  localparam int PRM_W = $clog2(PARAM_COUNT);
  localparam int WORDS = FX_COUNT * PARAM_COUNT;
  localparam int DEPTH = PRESET_COUNT * WORDS;
  localparam int AW    = $clog2(DEPTH);

  // Handshake: save_req/load_req are sampled only on a rising edge while
  // IDLE (save wins a tie, anything arriving while busy is dropped);
  // completion is a single-cycle done pulse, and wr_en is a fire-and-forget
  // strobe with no back-pressure from the controller.

  seq_state_t        state, state_n;
  logic [FX_W-1:0]   cnt_fx;
  logic [PRM_W-1:0]  cnt_param;
  logic [SEL_W-1:0]  slot_q;
  logic              last_idx;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [PARAM_W-1:0] ram_rdata;
  logic [PARAM_W-1:0] save_word;

  assign last_idx = (cnt_fx == FX_W'(FX_COUNT - 1)) &&
                    (cnt_param == PRM_W'(PARAM_COUNT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (save_req)      state_n = SAVE;
        else if (load_req) state_n = LOAD;
      end
      SAVE:      if (last_idx) state_n = DONE;
      LOAD:      if (last_idx) state_n = LOAD_TAIL;
      LOAD_TAIL: state_n = DONE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign lock      = busy;
  assign done      = (state == DONE);
  assign dbg_state = state;

  // Counters hold at the last word once reached, so the address can never
  // spill into the neighbouring slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_fx     <= '0;
      cnt_param  <= '0;
      slot_q     <= '0;
      slot_valid <= '0;
      wr_en      <= 1'b0;
      wr_fx      <= '0;
      wr_param   <= '0;
    end else begin
      wr_en <= (state == LOAD);
      if (state == LOAD) begin
        wr_fx    <= cnt_fx;
        wr_param <= cnt_param;
      end

      if (state == IDLE) begin
        cnt_fx    <= '0;
        cnt_param <= '0;
        if (save_req || load_req) slot_q <= preset_sel;
      end else if ((state == SAVE || state == LOAD) && !last_idx) begin
        if (cnt_param == PRM_W'(PARAM_COUNT - 1)) begin
          cnt_param <= '0;
          cnt_fx    <= cnt_fx + 1'b1;
        end else begin
          cnt_param <= cnt_param + 1'b1;
        end
      end

      if (state == SAVE && last_idx) slot_valid[slot_q] <= 1'b1;
    end
  end

  // Reset gates the write strobe so an aborted save stops on the same edge.
  assign ram_we    = (state == SAVE) && !reset;
  assign ram_addr  = AW'(int'(slot_q) * WORDS + int'(cnt_fx) * PARAM_COUNT + int'(cnt_param));
  assign save_word = params[cnt_fx][cnt_param];

  preset_ram #(
    .DEPTH (DEPTH),
    .W     (PARAM_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (save_word),
    .rdata (ram_rdata)
  );

  // Empty slots replay factory values with identical timing.
  assign wr_data = !wr_en ? '0 :
                   slot_valid[slot_q] ? ram_rdata :
                   PARAM_W'(param_default(32'(wr_fx), 32'(wr_param)));

endmodule

// File: tb/tb_preset_sequencer.sv
// Randomized scoreboard bench for preset_sequencer against a slot-array
// reference model.
import lab_pkg::*;

module tb_preset_sequencer;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        save_req, load_req;
  logic [1:0]                  preset_sel;
  logic [15:0][7:0][6:0]       params;
  logic                        busy, lock, done, wr_en;
  logic [3:0]                  wr_fx;
  logic [2:0]                  wr_param;
  logic [6:0]                  wr_data;
  logic [3:0]                  slot_valid;
  seq_state_t                  dbg_state;

  preset_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .save_req   (save_req),
    .load_req   (load_req),
    .preset_sel (preset_sel),
    .params     (params),
    .busy       (busy),
    .lock       (lock),
    .done       (done),
    .wr_en      (wr_en),
    .wr_fx      (wr_fx),
    .wr_param   (wr_param),
    .wr_data    (wr_data),
    .slot_valid (slot_valid),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [6:0]  mdl_mem [4][16][8];
  bit          mdl_valid [4];
  logic [13:0] exp_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [3:0] mdl_valid_vec();
    logic [3:0] v;
    for (int s = 0; s < 4; s++) v[s] = mdl_valid[s];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic push_load(input int sel);
    logic [6:0] d;
    for (int f = 0; f < 16; f++)
      for (int p = 0; p < 8; p++) begin
        d = mdl_valid[sel] ? mdl_mem[sel][f][p] : 7'(param_default(f, p));
        exp_q.push_back({4'(f), 3'(p), d});
      end
  endtask

  task automatic params_default();
    for (int f = 0; f < 16; f++)
      for (int p = 0; p < 8; p++) params[f][p] = 7'(param_default(f, p));
  endtask

  task automatic params_random();
    for (int f = 0; f < 16; f++)
      for (int p = 0; p < 8; p++) params[f][p] = 7'($urandom_range(0, 127));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL wr_unexpected: fx=%0d param=%0d data=%0h but no write expected",
                 wr_fx, wr_param, wr_data);
      end else begin
        check("wr_word", 32'({wr_fx, wr_param, wr_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_lock", 32'(lock), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_fx", 32'(wr_fx), 0);
    check("rst_wr_param", 32'(wr_param), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_slot_valid", 32'(slot_valid), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    for (int s = 0; s < 4; s++) mdl_valid[s] = 1'b0;
  endtask

  // One request; optional mid-sequence load_req injection or reset at cycle k.
  task automatic run_op(input bit sv, input bit ld, input int sel,
                        input int inject_at, input int reset_at);
    int  k;
    int  lat_exp;
    bit  seen;
    logic [6:0] snap [16][8];
    lat_exp = sv ? 129 : 130;
    for (int f = 0; f < 16; f++)
      for (int p = 0; p < 8; p++) snap[f][p] = params[f][p];
    if (!sv && ld) push_load(sel);

    @(negedge clk);
    save_req   = sv;
    load_req   = ld;
    preset_sel = 2'(sel);
    @(negedge clk);
    save_req = 1'b0;
    load_req = 1'b0;
    seen = 1'b0;
    for (k = 1; k <= 140; k++) begin
      if (reset_at == k) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_slot_valid", 32'(slot_valid), 0);
        for (int s = 0; s < 4; s++) mdl_valid[s] = 1'b0;
        return;
      end
      load_req = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy !== 1'b1 || lock !== 1'b1) check("busy_during_seq", 32'({busy, lock}), 3);
      if (inject_at == k) begin
        load_req   = 1'b1;
        preset_sel = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
    end
    check("done_latency", seen ? 32'(k) : 32'hffff, 32'(lat_exp));
    check("busy_at_done", 32'(busy), 1);
    @(negedge clk);
    check("done_one_cycle", 32'({done, busy}), 0);
    if (sv) begin
      for (int f = 0; f < 16; f++)
        for (int p = 0; p < 8; p++) mdl_mem[sel][f][p] = snap[f][p];
      mdl_valid[sel] = 1'b1;
    end
    check("slot_valid", 32'(slot_valid), 32'(mdl_valid_vec()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    save_req   = 1'b0;
    load_req   = 1'b0;
    preset_sel = '0;
    params_default();
    do_reset();

    // Load from a never-saved slot yields factory values.
    run_op(1'b0, 1'b1, 0, 0, 0);

    // Save slot 1 with one modified parameter, then reload it after editing.
    params_default();
    params[2][1] = 7'h55;
    run_op(1'b1, 1'b0, 1, 0, 0);
    params[2][1] = 7'h10;
    run_op(1'b0, 1'b1, 1, 0, 0);

    // Simultaneous save and load: save wins.
    params_random();
    run_op(1'b1, 1'b1, 2, 0, 0);

    // Load request mid-save is dropped; a following load is honoured.
    params_random();
    run_op(1'b1, 1'b0, 0, 50, 0);
    repeat (3) begin
      @(negedge clk);
      check("no_extra_done", 32'(done), 0);
    end
    run_op(1'b0, 1'b1, 0, 0, 0);

    // Reset partway through a save leaves the slot invalid.
    params_random();
    run_op(1'b1, 1'b0, 3, 0, 60);
    run_op(1'b0, 1'b1, 3, 0, 0);

    // Randomized traffic.
    for (int r = 0; r < 12; r++) begin
      int op;
      int sel;
      op  = $urandom_range(0, 2);
      sel = $urandom_range(0, 3);
      params_random();
      run_op(op != 1, op != 0, sel, 0, 0);
    end

    repeat (4) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/preset_sequencer.md
PRESET_SEQUENCER -- requirements
Module: preset_sequencer

Interface
REQ-001 SHALL have parameter FX_COUNT, default 16, number of effects.
REQ-002 SHALL have parameter PARAM_COUNT, default 8, parameters per effect.
REQ-003 SHALL have parameter PARAM_W, default 7, parameter value width.
REQ-004 SHALL have parameter PRESET_COUNT, default 4, number of stored preset slots.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 save_req  in  1  request to store the live param bank into slot preset_sel.
REQ-008 load_req  in  1  request to restore slot preset_sel into the live param bank.
REQ-009 preset_sel  in  $clog2(PRESET_COUNT)  target slot.
REQ-010 params  in  [FX_COUNT][PARAM_COUNT] x PARAM_W  live param bank from controller.
REQ-011 busy  out  1  high while a save/load sequence is in progress.
REQ-012 lock  out  1  front-panel inc/dec lockout to controller; equals busy.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 wr_en  out  1  param write strobe to controller bank.
REQ-015 wr_fx  out  $clog2(FX_COUNT)  effect index of write.
REQ-016 wr_param  out  $clog2(PARAM_COUNT)  parameter index of write.
REQ-017 wr_data  out  PARAM_W  value written.
REQ-018 slot_valid  out  PRESET_COUNT  bit per slot, set once that slot has been saved.

Function
REQ-019 FSM states SHALL be IDLE, SAVE, LOAD, LOAD_TAIL, DONE.
REQ-020 In IDLE, save_req high at a rising edge SHALL move to SAVE and latch preset_sel; load_req alone SHALL move to LOAD and latch preset_sel.
REQ-021 save_req and load_req high together SHALL start a save; load ignored.
REQ-022 Requests while not IDLE SHALL be ignored, not queued.
REQ-023 Word index i = fx*PARAM_COUNT + param, counter 0..FX_COUNT*PARAM_COUNT-1 (127 at defaults), fx-major order.
REQ-024 SAVE SHALL write params[fx][param] to preset RAM address slot*128+i, one word per cycle, 128 cycles, then set slot_valid[slot] and go to DONE.
REQ-025 LOAD SHALL issue one RAM read per cycle for i=0..127; RAM read latency is 1 cycle, so wr_en/wr_fx/wr_param/wr_data for index i SHALL appear the cycle after its read.
REQ-026 After the read of i=127, FSM SHALL spend one cycle in LOAD_TAIL (final write) then go to DONE.
REQ-027 Load of a slot with slot_valid=0 SHALL keep identical timing but drive wr_data = param_default(fx,param).
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 busy SHALL be high in SAVE, LOAD, LOAD_TAIL, DONE; low in IDLE.
REQ-030 Latency: save request edge to done = 129 cycles; load request edge to done = 130 cycles.
REQ-031 wr_en SHALL never assert during SAVE or IDLE; exactly 128 wr_en pulses per load.
REQ-032 Index counter SHALL stop at 127 and never wrap into the next slot's addresses.

Reset
REQ-033 reset SHALL force IDLE, busy=0, lock=0, done=0, wr_en=0, wr_fx=0, wr_param=0, wr_data=0, slot_valid=0, counter=0.
REQ-034 reset mid-sequence SHALL abort immediately; no further wr_en or RAM writes; partially written slot remains invalid.
REQ-035 Preset RAM contents SHALL not be reset.

Structure
REQ-036 PRESET_COUNT, the FSM state enum and param_default() SHALL live in lab_pkg.
REQ-037 Storage SHALL be a sub-module preset_ram: single-port synchronous RAM, PRESET_COUNT*FX_COUNT*PARAM_COUNT words x PARAM_W, 1-cycle read latency.

Verification
REQ-038 Reset, pulse load_req slot 0 (never saved) -> 128 wr_en pulses, wr_data = param_default(fx,param), done at cycle 130, slot_valid=0000.
REQ-039 Set params[2][1]=0x55, others default, save slot 1 -> busy for 129 cycles, done pulse, slot_valid=0010, no wr_en.
REQ-040 Change params[2][1]=0x10, load slot 1 -> write with wr_fx=2, wr_param=1 carries 0x55; all other writes match saved values.
REQ-041 save_req and load_req same cycle, slot 2 -> save performed, slot_valid[2]=1, no wr_en.
REQ-042 load_req pulsed at cycle 50 of a save -> ignored; single done; second request after done accepted.
REQ-043 reset asserted at cycle 60 of save to slot 3 -> busy=0 next cycle, slot_valid[3]=0, subsequent load slot 3 yields defaults.
